tlk2711_axi_rd_arb: RTL and testbench
=====================================

# tlk2711_axi_rd_arb

- Shares one PS AXI4 read port between the tlk2711a and tlk2711b TX DMA read masters.
- Arbitration is round-robin, one burst at a time: the granted AR is latched and forwarded, and the R beats are routed back to that master until `rlast`.
- Sits between the two `tlk2711_top` instances and the PS HP slave, in the `clk` domain.
- The write channels are not touched.

## Interface

Parameters:
- `ADDR_WIDTH`, 48, AXI address width
- `AXI_RDATA_WIDTH`, 64, R data width
- `WDOG_CYCLES`, 4096, watchdog limit in cycles (used only with the macro)

Ports (`s0` = tlk2711a, `s1` = tlk2711b, `m` = PS port):
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  reset; synchronous, active-high
- `sN_arvalid`/`sN_arready`  in/out  1 each  AR handshake, N=0,1
- `sN_arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arprot`/`arcache`/`aruser`  in  4/ADDR_WIDTH/8/3/2/3/4/1  AR fields, N=0,1
- `sN_rdata`/`rresp`/`rlast`/`rvalid`  out  AXI_RDATA_WIDTH/2/1/1  R channel, N=0,1
- `sN_rready`  in  1  R ready, N=0,1
- `m_ar*`  out (`m_arready` in)  same widths as `sN_ar*`  AR toward PS
- `m_rdata`/`rresp`/`rlast`/`rvalid`  in  same widths as `sN_r*`  R from PS
- `m_rready`  out  1  R ready toward PS
- `o_grant`  out  2  one-hot owner of the current burst; 0 when idle
- `o_busy`  out  1  state is not IDLE
- `i_err_clr`  in  1  clears `o_wdog_err`
- `o_wdog_err`  out  1  sticky watchdog flag

## Operation

State machine states: IDLE, ADDR, DATA.

IDLE:
- Grant is computed combinationally from the `sN_arvalid` requests.
- A single requester wins outright.
- If both request, the winner is the master not in the `last` register. `last` resets to 1, so s0 wins first after reset.
- `s<win>_arready` = 1; every other `arready` = 0.
- On the handshake: latch all AR fields into the `m_ar*` registers, set `o_grant`, set `last` = winner, go to ADDR.

ADDR:
- `m_arvalid` = 1 with the latched fields.
- Fields are held stable until `m_arready`, then go to DATA.
- `m_arvalid` deasserts the cycle after the handshake.

DATA:
- R is routed combinationally:
  - `s<g>_r*` = `m_r*`
  - `m_rready` = `s<g>_rready`
  - the non-granted `sN_rvalid` = 0
- On `m_rvalid & m_rready & m_rlast`, go to IDLE and clear `o_grant`.
- `rresp` is passed through unmodified; SLVERR/DECERR do not end the burst early.

General rules:
- All `sN_arready` = 0 outside IDLE.
- Only one burst is outstanding; the block never issues a second AR before `rlast`.
- `m_rvalid` while in IDLE or ADDR is a protocol violation. `m_rready` = 0, and the beat is never routed.
- `m_arid` is passed through; the ID space is not remapped.

## Timing

Reset values:
- state IDLE, `last` = 1
- `m_arvalid` = 0, `m_ar*` fields = 0
- `o_grant` = 0, `o_busy` = 0, `o_wdog_err` = 0
- every `sN_arready` and `sN_rvalid` = 0

Latency and behaviour:
- AR latency: `sN` handshake in cycle T; `m_arvalid` = 1 in T+1.
- R path: zero-latency combinational pass-through, no added bubbles.
- Back-to-back bursts: the `rlast` beat is in cycle T, IDLE in T+1, and a new `sN_arready` can assert in T+1.
- Requests arriving in the `rlast` cycle wait until T+1.
- Simultaneous requests alternate grants strictly: s0, s1, s0, ...
- A single persistent requester is granted every burst.
- `rst` mid-burst: the block returns to IDLE next edge and drops all valids. Both masters and the PS port share `rst`, so no burst resumes.

## Configuration

`TLK2711_ARB_WDOG_EN`, defined:
- A 16-bit counter is cleared on entry to ADDR and increments in ADDR and DATA.
- When it reaches `WDOG_CYCLES`, `o_wdog_err` sets and stays set until `i_err_clr` or `rst`.
- `i_err_clr` wins over a simultaneous set.
- The burst is not aborted.

`TLK2711_ARB_WDOG_EN`, undefined:
- No counter is built.
- `o_wdog_err` = 0 and `i_err_clr` is ignored.

## Structure

- Shared package `tlk2711_pkg`: state enum (IDLE/ADDR/DATA), the AXI AR field widths as localparams (ID 4, LEN 8, SIZE 3, BURST 2, PROT 3, CACHE 4), and a packed AR-bundle struct.
- One sub-module: `tlk2711_rr_arb2`, the two-request round-robin grant logic with the `last` register. The FSM and the muxes stay in the top module.

## Test plan

1. Reset, then s0 alone issues `araddr` 0x1000, `arlen` 7 → `m_arvalid` in T+1 with identical fields, `o_grant` = 01, 8 beats routed to s0, `s1_rvalid` held 0, IDLE after `rlast`.
2. s0 and s1 both request continuously for 4 bursts → grant order s0, s1, s0, s1; no AR is issued before the previous `rlast`.
3. `m_arready` held low 20 cycles → `m_arvalid` and fields stable throughout, `sN_arready` stays 0, and the burst completes normally once ready.
4. s1 `rready` toggles 1/0 during a 16-beat burst → `m_rready` mirrors it exactly, no beat is lost or duplicated, and the data order matches the source.
5. `rst` asserted on beat 3 of 8 → next cycle IDLE, `o_grant` = 0, all valids 0, and the next request is granted to s0.
6. With `TLK2711_ARB_WDOG_EN` and `WDOG_CYCLES` = 64, `m_arready` stuck low → `o_wdog_err` = 1 at cycle 64 after entering ADDR; `i_err_clr` pulse → 0. Without the macro, `o_wdog_err` stays 0.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: shared state encoding, AXI AR field widths and the AR field bundle
// used by the tlk2711 AXI read arbiter.
package tlk2711_pkg;

    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int PROT_W  = 3;
    localparam int CACHE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // AR attributes that travel with the address; the address itself is
    // kept separately because its width is a module parameter.
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic [PROT_W-1:0]  prot;
        logic [CACHE_W-1:0] cache;
        logic               user;
    } ar_bundle_t;

endpackage

// File: rtl/tlk2711_rr_arb2.sv
// tlk2711_rr_arb2: two-request round-robin grant; last holds the index of the
// most recent winner and resets to 1 so requester 0 wins the first tie.
module tlk2711_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last;

    always_comb grant = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (take)
            last <= grant[1];
    end

endmodule

// File: rtl/tlk2711_axi_rd_arb.sv
// tlk2711_axi_rd_arb: shares one PS AXI4 read port between two TX DMA read masters,
// one burst at a time. Optional watchdog is built when TLK2711_ARB_WDOG_EN is defined.
module tlk2711_axi_rd_arb
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH      = 48,
    parameter int AXI_RDATA_WIDTH = 64,
    parameter int WDOG_CYCLES     = 4096
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       s0_arvalid,
    output logic                       s0_arready,
    input  logic [ID_W-1:0]            s0_arid,
    input  logic [ADDR_WIDTH-1:0]      s0_araddr,
    input  logic [LEN_W-1:0]           s0_arlen,
    input  logic [SIZE_W-1:0]          s0_arsize,
    input  logic [BURST_W-1:0]         s0_arburst,
    input  logic [PROT_W-1:0]          s0_arprot,
    input  logic [CACHE_W-1:0]         s0_arcache,
    input  logic                       s0_aruser,
    output logic [AXI_RDATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]                 s0_rresp,
    output logic                       s0_rlast,
    output logic                       s0_rvalid,
    input  logic                       s0_rready,

    input  logic                       s1_arvalid,
    output logic                       s1_arready,
    input  logic [ID_W-1:0]            s1_arid,
    input  logic [ADDR_WIDTH-1:0]      s1_araddr,
    input  logic [LEN_W-1:0]           s1_arlen,
    input  logic [SIZE_W-1:0]          s1_arsize,
    input  logic [BURST_W-1:0]         s1_arburst,
    input  logic [PROT_W-1:0]          s1_arprot,
    input  logic [CACHE_W-1:0]         s1_arcache,
    input  logic                       s1_aruser,
    output logic [AXI_RDATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]                 s1_rresp,
    output logic                       s1_rlast,
    output logic                       s1_rvalid,
    input  logic                       s1_rready,

    output logic                       m_arvalid,
    input  logic                       m_arready,
    output logic [ID_W-1:0]            m_arid,
    output logic [ADDR_WIDTH-1:0]      m_araddr,
    output logic [LEN_W-1:0]           m_arlen,
    output logic [SIZE_W-1:0]          m_arsize,
    output logic [BURST_W-1:0]         m_arburst,
    output logic [PROT_W-1:0]          m_arprot,
    output logic [CACHE_W-1:0]         m_arcache,
    output logic                       m_aruser,
    input  logic [AXI_RDATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_rlast,
    input  logic                       m_rvalid,
    output logic                       m_rready,

    output logic [1:0]                 o_grant,
    output logic                       o_busy,
    input  logic                       i_err_clr,
    output logic                       o_wdog_err
);

    arb_state_t            state, state_nxt;
    logic [1:0]            grant;
    logic                  ar_hs, r_done;
    ar_bundle_t            ar_q, ar_sel;
    logic [ADDR_WIDTH-1:0] addr_q, addr_sel;

    tlk2711_rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   ({s1_arvalid, s0_arvalid}),
        .take  (ar_hs),
        .grant (grant)
    );

    always_comb begin
        s0_arready = (state == IDLE) && grant[0];
        s1_arready = (state == IDLE) && grant[1];
        ar_hs      = (state == IDLE) && (grant != 2'b00);
        ar_sel     = grant[1] ?
            '{id: s1_arid, len: s1_arlen, size: s1_arsize, burst: s1_arburst,
              prot: s1_arprot, cache: s1_arcache, user: s1_aruser} :
            '{id: s0_arid, len: s0_arlen, size: s0_arsize, burst: s0_arburst,
              prot: s0_arprot, cache: s0_arcache, user: s0_aruser};
        addr_sel   = grant[1] ? s1_araddr : s0_araddr;
        // A beat outside DATA is a protocol violation: never accept or route it.
        m_rready   = (state == DATA) && (o_grant[1] ? s1_rready : s0_rready);
        r_done     = m_rvalid && m_rready && m_rlast;
        state_nxt  = (state == IDLE && ar_hs)     ? ADDR :
                     (state == ADDR && m_arready) ? DATA :
                     (state == DATA && r_done)    ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ar_q    <= '0;
            addr_q  <= '0;
            o_grant <= '0;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                ar_q    <= ar_sel;
                addr_q  <= addr_sel;
                o_grant <= grant;
            end else if (state == DATA && r_done) begin
                o_grant <= '0;
            end
        end
    end

    assign o_busy    = (state != IDLE);
    assign m_arvalid = (state == ADDR);
    assign m_arid    = ar_q.id;
    assign m_araddr  = addr_q;
    assign m_arlen   = ar_q.len;
    assign m_arsize  = ar_q.size;
    assign m_arburst = ar_q.burst;
    assign m_arprot  = ar_q.prot;
    assign m_arcache = ar_q.cache;
    assign m_aruser  = ar_q.user;

    assign s0_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s0_rvalid = (state == DATA) && o_grant[0] && m_rvalid;
    assign s1_rdata  = m_rdata;
    assign s1_rresp  = m_rresp;
    assign s1_rlast  = m_rlast;
    assign s1_rvalid = (state == DATA) && o_grant[1] && m_rvalid;

`ifdef TLK2711_ARB_WDOG_EN
    logic [15:0] wdog_cnt;

    // Counter saturates so a very long stall cannot wrap and re-trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt   <= '0;
            o_wdog_err <= 1'b0;
        end else begin
            wdog_cnt   <= ar_hs ? '0 : (o_busy && wdog_cnt != '1) ? wdog_cnt + 16'd1 : wdog_cnt;
            o_wdog_err <= i_err_clr ? 1'b0 :
                          o_wdog_err | (o_busy && (wdog_cnt + 16'd1) == 16'(WDOG_CYCLES));
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_wdog_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tlk2711_axi_rd_arb.sv
// tb_tlk2711_axi_rd_arb: self-checking bench; the bench plays both DMA masters and the
// PS slave and predicts grants and routing from the arbitration rules.
module tb_tlk2711_axi_rd_arb;

    localparam int AW = 48;
    localparam int DW = 64;
`ifdef TLK2711_ARB_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;

    logic          s0_arvalid = 0, s0_arready;
    logic [3:0]    s0_arid = 0;
    logic [AW-1:0] s0_araddr = 0;
    logic [7:0]    s0_arlen = 0;
    logic [2:0]    s0_arsize = 0, s0_arprot = 0;
    logic [1:0]    s0_arburst = 0;
    logic [3:0]    s0_arcache = 0;
    logic          s0_aruser = 0;
    logic [DW-1:0] s0_rdata;
    logic [1:0]    s0_rresp;
    logic          s0_rlast, s0_rvalid, s0_rready = 0;

    logic          s1_arvalid = 0, s1_arready;
    logic [3:0]    s1_arid = 0;
    logic [AW-1:0] s1_araddr = 0;
    logic [7:0]    s1_arlen = 0;
    logic [2:0]    s1_arsize = 0, s1_arprot = 0;
    logic [1:0]    s1_arburst = 0;
    logic [3:0]    s1_arcache = 0;
    logic          s1_aruser = 0;
    logic [DW-1:0] s1_rdata;
    logic [1:0]    s1_rresp;
    logic          s1_rlast, s1_rvalid, s1_rready = 0;

    logic          m_arvalid, m_arready = 0;
    logic [3:0]    m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize, m_arprot;
    logic [1:0]    m_arburst;
    logic [3:0]    m_arcache;
    logic          m_aruser;
    logic [DW-1:0] m_rdata = 0;
    logic [1:0]    m_rresp = 0;
    logic          m_rlast = 0, m_rvalid = 0, m_rready;

    logic [1:0] o_grant;
    logic       o_busy, i_err_clr = 0, o_wdog_err;

    int checks = 0, failures = 0;

    logic [72:0] m_f;
    assign m_f = {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arprot, m_arcache, m_aruser};

    always #5 clk = ~clk;

    tlk2711_axi_rd_arb #(.ADDR_WIDTH(AW), .AXI_RDATA_WIDTH(DW), .WDOG_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arprot(s0_arprot),
        .s0_arcache(s0_arcache), .s0_aruser(s0_aruser), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arprot(s1_arprot),
        .s1_arcache(s1_arcache), .s1_aruser(s1_aruser), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arprot(m_arprot),
        .m_arcache(m_arcache), .m_aruser(m_aruser), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .o_grant(o_grant), .o_busy(o_busy), .i_err_clr(i_err_clr), .o_wdog_err(o_wdog_err)
    );

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rand_a();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Field order: id, addr, len, size, burst, prot, cache, user.
    function automatic logic [72:0] rand_f(input logic [47:0] a, input logic [7:0] l);
        return {4'($urandom), a, l, 13'($urandom)};
    endfunction

    function automatic logic [63:0] rand_d();
        return {$urandom, $urandom};
    endfunction

    task automatic set_master(input int m, input logic v, input logic [72:0] f);
        if (m == 0) begin
            {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arprot, s0_arcache, s0_aruser} = f;
            s0_arvalid = v;
        end else begin
            {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arprot, s1_arcache, s1_aruser} = f;
            s1_arvalid = v;
        end
    endtask

    task automatic ps_beat(input logic v, input logic [63:0] d, input logic l, input logic [1:0] r);
        m_rvalid = v;
        m_rdata  = d;
        m_rlast  = l;
        m_rresp  = r;
    endtask

    task automatic test_reset();
        rst = 1;
        s0_rready = 1;
        s1_rready = 1;
        ps_beat(1, rand_d(), 1, 2'b00);
        repeat (3) edge1();
        @(negedge clk);
        checks++;
        if ({m_arvalid, m_f, o_grant, o_busy, o_wdog_err, s0_arready, s1_arready,
             s0_rvalid, s1_rvalid, m_rready} !== '0)
            begin failures++; $display("FAIL reset_state got arv=%b f=%h g=%b busy=%b err=%b ary=%b%b rv=%b%b rr=%b exp all 0",
                m_arvalid, m_f, o_grant, o_busy, o_wdog_err, s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_rready); end
        edge1();
        rst = 0;
        ps_beat(0, '0, 0, 2'b00);
    endtask

    task automatic test_single();
        logic [72:0] f;
        logic [63:0] d;
        logic [1:0]  r;
        f = rand_f(48'h1000, 8'd7);
        edge1();
        set_master(0, 1, f);
        @(negedge clk);
        checks++;
        if ({s1_arready, s0_arready} !== 2'b01)
            begin failures++; $display("FAIL single_arready got=%b exp=01", {s1_arready, s0_arready}); end
        edge1();
        s0_arvalid = 0;
        @(negedge clk);
        checks++;
        if ({m_arvalid, m_f, o_grant, o_busy} !== {1'b1, f, 2'b01, 1'b1})
            begin failures++; $display("FAIL single_ar got=%b %h %b %b exp=1 %h 01 1", m_arvalid, m_f, o_grant, o_busy, f); end
        m_arready = 1;
        edge1();
        m_arready = 0;
        for (int b = 0; b < 8; b++) begin
            d = rand_d();
            r = 2'($urandom);
            ps_beat(1, d, b == 7, r);
            @(negedge clk);
            checks++;
            if ({s0_rvalid, s0_rdata, s0_rlast, s0_rresp, s1_rvalid, m_rready, m_arvalid} !==
                {1'b1, d, b == 7, r, 1'b0, 1'b1, 1'b0})
                begin failures++; $display("FAIL single_beat%0d got=%b %h %b %b %b %b %b exp=1 %h %b %b 0 1 0", b,
                    s0_rvalid, s0_rdata, s0_rlast, s0_rresp, s1_rvalid, m_rready, m_arvalid, d, b == 7, r); end
            edge1();
        end
        ps_beat(0, '0, 0, 2'b00);
        @(negedge clk);
        checks++;
        if ({o_busy, o_grant, m_arvalid} !== 4'b0)
            begin failures++; $display("FAIL single_idle got=%b %b %b exp=0 00 0", o_busy, o_grant, m_arvalid); end
    endtask

    task automatic test_round_robin();
        logic [72:0] f[2];
        logic [72:0] ef;
        logic [63:0] d;
        int model_last, w;
        rst = 1;
        edge1();
        rst = 0;
        model_last = 1;
        f[0] = rand_f(rand_a(), 8'($urandom_range(0, 3)));
        f[1] = rand_f(rand_a(), 8'($urandom_range(0, 3)));
        set_master(0, 1, f[0]);
        set_master(1, 1, f[1]);
        for (int k = 0; k < 4; k++) begin
            w = (model_last == 1) ? 0 : 1;
            @(negedge clk);
            checks++;
            if ({s1_arready, s0_arready} !== ((w == 1) ? 2'b10 : 2'b01))
                begin failures++; $display("FAIL rr_grant burst%0d got=%b exp_winner=s%0d", k, {s1_arready, s0_arready}, w); end
            edge1();
            ef = f[w];
            model_last = w;
            f[w] = rand_f(rand_a(), 8'($urandom_range(0, 3)));
            set_master(w, 1, f[w]);
            m_arready = 1;
            @(negedge clk);
            checks++;
            if ({m_arvalid, m_f, o_grant} !== {1'b1, ef, (w == 1), (w == 0)})
                begin failures++; $display("FAIL rr_ar burst%0d got=%b %h %b exp=1 %h s%0d", k, m_arvalid, m_f, o_grant, ef, w); end
            edge1();
            m_arready = 0;
            for (int b = 0; b <= int'(ef[20:13]); b++) begin
                d = rand_d();
                ps_beat(1, d, b == int'(ef[20:13]), 2'b00);
                @(negedge clk);
                checks++;
                if ({s0_rvalid, s1_rvalid, (w == 1) ? s1_rdata : s0_rdata, s0_arready, s1_arready, m_arvalid} !==
                    {(w == 0), (w == 1), d, 3'b000})
                    begin failures++; $display("FAIL rr_beat burst%0d beat%0d got=%b%b %h ary=%b%b arv=%b exp s%0d %h no AR",
                        k, b, s0_rvalid, s1_rvalid, (w == 1) ? s1_rdata : s0_rdata, s0_arready, s1_arready, m_arvalid, w, d); end
                edge1();
            end
            ps_beat(0, '0, 0, 2'b00);
        end
        s0_arvalid = 0;
        s1_arvalid = 0;
    endtask

    task automatic test_ar_stall();
        logic [72:0] f;
        logic [63:0] d;
        f = rand_f(rand_a(), 8'd0);
        edge1();
        set_master(1, 1, f);
        edge1();
        s1_arvalid = 0;
        set_master(0, 1, rand_f(rand_a(), 8'd0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({m_arvalid, m_f, s0_arready, s1_arready, o_grant} !== {1'b1, f, 2'b00, 2'b10})
                begin failures++; $display("FAIL stall_hold cyc%0d got=%b %h %b%b %b exp=1 %h 00 10", i,
                    m_arvalid, m_f, s0_arready, s1_arready, o_grant, f); end
            edge1();
        end
        m_arready = 1;
        edge1();
        m_arready = 0;
        d = rand_d();
        ps_beat(1, d, 1, 2'b10);
        @(negedge clk);
        checks++;
        if ({s1_rvalid, s1_rdata, s1_rresp, s0_rvalid, m_arvalid} !== {1'b1, d, 2'b10, 2'b00})
            begin failures++; $display("FAIL stall_beat got=%b %h %b %b %b exp=1 %h 10 0 0",
                s1_rvalid, s1_rdata, s1_rresp, s0_rvalid, m_arvalid, d); end
        edge1();
        ps_beat(0, '0, 0, 2'b00);
        @(negedge clk);
        checks++;
        if ({s1_arready, s0_arready, o_busy} !== 3'b010)
            begin failures++; $display("FAIL stall_next got=%b%b busy=%b exp=01 busy=0", s1_arready, s0_arready, o_busy); end
        s0_arvalid = 0;
    endtask

    task automatic test_rready_toggle();
        logic [72:0] f;
        logic [63:0] src[16];
        logic [63:0] got[$];
        int idx;
        f = rand_f(rand_a(), 8'd15);
        for (int i = 0; i < 16; i++) src[i] = rand_d();
        idx = 0;
        edge1();
        set_master(1, 1, f);
        edge1();
        s1_arvalid = 0;
        m_arready = 1;
        edge1();
        m_arready = 0;
        for (int cyc = 0; cyc < 100 && idx < 16; cyc++) begin
            s1_rready = (cyc % 2 == 0);
            ps_beat(1, src[idx], idx == 15, 2'b00);
            @(negedge clk);
            checks++;
            if ({m_rready, s1_rvalid, s0_rvalid} !== {s1_rready, 2'b10})
                begin failures++; $display("FAIL toggle_rready cyc%0d got=%b %b %b exp=%b 1 0", cyc,
                    m_rready, s1_rvalid, s0_rvalid, s1_rready); end
            if (s1_rvalid && s1_rready) got.push_back(s1_rdata);
            if (m_rvalid && m_rready) idx++;
            edge1();
        end
        ps_beat(0, '0, 0, 2'b00);
        s1_rready = 1;
        checks++;
        if (got.size() != 16)
            begin failures++; $display("FAIL toggle_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            checks++;
            if (got[i] !== src[i])
                begin failures++; $display("FAIL toggle_data beat%0d got=%h exp=%h", i, got[i], src[i]); end
        end
        @(negedge clk);
        checks++;
        if ({o_busy, o_grant} !== 3'b000)
            begin failures++; $display("FAIL toggle_idle got=%b %b exp=0 00", o_busy, o_grant); end
    endtask

    task automatic test_reset_mid_burst();
        logic [72:0] f;
        f = rand_f(rand_a(), 8'd7);
        edge1();
        set_master(0, 1, f);
        edge1();
        s0_arvalid = 0;
        m_arready = 1;
        edge1();
        m_arready = 0;
        s0_rready = 1;
        for (int b = 0; b < 2; b++) begin
            ps_beat(1, rand_d(), 0, 2'b00);
            edge1();
        end
        ps_beat(1, rand_d(), 0, 2'b00);
        rst = 1;
        edge1();
        rst = 0;
        set_master(0, 1, rand_f(rand_a(), 8'd0));
        set_master(1, 1, rand_f(rand_a(), 8'd0));
        @(negedge clk);
        checks++;
        if ({o_busy, o_grant, m_arvalid, s0_rvalid, s1_rvalid, m_rready} !== 7'b0)
            begin failures++; $display("FAIL rst_mid got=%b %b %b %b %b %b exp all 0",
                o_busy, o_grant, m_arvalid, s0_rvalid, s1_rvalid, m_rready); end
        checks++;
        if ({s1_arready, s0_arready} !== 2'b01)
            begin failures++; $display("FAIL rst_mid_grant got=%b exp=01", {s1_arready, s0_arready}); end
        s0_arvalid = 0;
        s1_arvalid = 0;
        ps_beat(0, '0, 0, 2'b00);
    endtask

    task automatic test_wdog();
        rst = 1;
        edge1();
        rst = 0;
        set_master(0, 1, rand_f(rand_a(), 8'd0));
        edge1();
        s0_arvalid = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            checks++;
            if (o_wdog_err !== (WDOG_EN && n >= 64))
                begin failures++; $display("FAIL wdog_set cyc%0d got=%b exp=%b", n, o_wdog_err, WDOG_EN && n >= 64); end
            edge1();
        end
        i_err_clr = 1;
        edge1();
        i_err_clr = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if ({o_wdog_err, o_busy} !== 2'b01)
                begin failures++; $display("FAIL wdog_clr cyc%0d got err=%b busy=%b exp err=0 busy=1", n, o_wdog_err, o_busy); end
            edge1();
        end
        m_arready = 1;
        edge1();
        m_arready = 0;
        ps_beat(1, rand_d(), 1, 2'b00);
        edge1();
        ps_beat(0, '0, 0, 2'b00);
        @(negedge clk);
        checks++;
        if ({o_busy, o_wdog_err} !== 2'b00)
            begin failures++; $display("FAIL wdog_done got busy=%b err=%b exp 0 0", o_busy, o_wdog_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ar_stall();
        test_rready_toggle();
        test_reset_mid_burst();
        test_wdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
